hs_rx_fifo: RTL and testbench

Receive stage sitting directly downstream of machineCPU on its send/ack/dados link. It takes the place of the peripheral's receive logic.
- Completes the four-phase handshake per nibble.
- Stores each captured nibble in a small FIFO.
- Presents the stored nibbles to local logic on a valid/ready port.
- Lets the peripheral consume data at its own pace. The CPU is back-pressured, never dropped.

---
 rtl/hs_rx_fifo.sv | 116 +++++++++++
 tb/tb_hs_rx_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_rx_fifo.sv
// Receive stage for the send/ack/dados link: four-phase handshake per nibble into a small
// FIFO, drained by local logic over a show-ahead valid/ready port.
module hs_rx_fifo #(
   parameter int unsigned DATA_W      = 4,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     send,
   input  logic [DATA_W-1:0]        dados,
   output logic                     ack,
   output logic [DATA_W-1:0]        dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [0:0] {StIdle, StWaitDrop} state_e;

   state_e                 state_q, state_d;
   logic                   ack_q, ack_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]        count_q, count_d;
   logic [DATA_W-1:0]      mem_q [DEPTH];
   logic [DATA_W-1:0]      mem_d [DEPTH];

   logic send_s;
   logic wr_en;
   logic pop;

   assign send_s     = sync_q[SYNC_STAGES-1];
   assign full       = (count_q == CntW'(DEPTH));
   assign dout_valid = (count_q != '0);
   assign pop        = dout_valid && dout_ready;
   assign dout       = mem_q[rd_ptr_q];
   assign ack        = ack_q;
   assign count      = count_q;

   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = send;
   end

   // Only IDLE writes, so a send held high is stored exactly once. Full uses the registered
   // count, so a pop while full lets the stalled write through one edge later.
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      wr_en   = 1'b0;
      case (state_q)
         StIdle: begin
            if (send_s && !full) begin
               wr_en   = 1'b1;
               ack_d   = 1'b1;
               state_d = StWaitDrop;
            end
         end
         StWaitDrop: begin
            if (!send_s) begin
               ack_d   = 1'b0;
               state_d = StIdle;
            end
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = dados;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         ack_q    <= 1'b0;
         sync_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         sync_q   <= sync_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: dout is only meaningful while dout_valid is high.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_hs_rx_fifo.sv
// Bench for hs_rx_fifo: directed handshake/latency scenarios plus random traffic, with a
// queue-based scoreboard checking data order, occupancy and flags every cycle.
module tb_hs_rx_fifo;

   localparam int unsigned DATA_W      = 4;
   localparam int unsigned DEPTH       = 4;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int          BUDGET      = 200;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   send;
   logic [DATA_W-1:0]      dados;
   logic                   ack;
   logic [DATA_W-1:0]      dout;
   logic                   dout_valid;
   logic                   dout_ready;
   logic [$clog2(DEPTH):0] count;
   logic                   full;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] model [$];
   logic [DATA_W-1:0] cur_data;
   logic              ack_prev = 1'b0;
   int                pre_size = 0;
   bit                rand_ready_en = 1'b0;

   hs_rx_fifo #(
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .send       (send),
      .dados      (dados),
      .ack        (ack),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .count      (count),
      .full       (full)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready_en) dout_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_ack(input logic val, output int edges);
      edges = 0;
      while (ack !== val && edges < BUDGET) begin
         tick();
         edges++;
      end
      if (ack !== val) check("ack_wait_timeout", 32'(ack), 32'(val));
   endtask

   task automatic send_nib(input logic [DATA_W-1:0] d, input int hold);
      int e;
      cur_data = d;
      dados    = d;
      send     = 1'b1;
      wait_ack(1'b1, e);
      repeat (hold) tick();
      send = 1'b0;
      wait_ack(1'b0, e);
      dados = DATA_W'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      dout_ready = 1'b1;
      while (dout_valid === 1'b1 && n < BUDGET) begin
         tick();
         n++;
      end
      dout_ready = 1'b0;
      check("drain_empty", 32'(dout_valid), 32'd0);
   endtask

   // Scoreboard: a write is signalled by the ack rise, a pop by valid&&ready at the edge.
   always @(negedge clk) begin
      if (!rst) begin
         model.delete();
         ack_prev = 1'b0;
         pre_size = 0;
         check("rst_ack", 32'(ack), 32'd0);
         check("rst_count", 32'(count), 32'd0);
         check("rst_valid", 32'(dout_valid), 32'd0);
      end else begin
         if (ack && !ack_prev) begin
            check("no_write_when_full", 32'(pre_size < int'(DEPTH)), 32'd1);
            model.push_back(cur_data);
         end
         ack_prev = ack;
         check("count", 32'(count), 32'(model.size()));
         check("dout_valid", 32'(dout_valid), 32'(model.size() != 0));
         check("full", 32'(full), 32'(model.size() == int'(DEPTH)));
         if (model.size() != 0) check("dout_order", 32'(dout), 32'(model[0]));
         pre_size = model.size();
         if (dout_valid && dout_ready && model.size() != 0) void'(model.pop_front());
      end
   end

   initial begin
      int e;
      rst        = 1'b0;
      send       = 1'b1;
      dados      = 4'h3;
      cur_data   = 4'h3;
      dout_ready = 1'b0;

      // 1: reset held with send high, then latency from release
      repeat (2) tick();
      check("t1_ack_in_reset", 32'(ack), 32'd0);
      rst = 1'b1;
      wait_ack(1'b1, e);
      check("t1_ack_latency", 32'(e), 32'(SYNC_STAGES + 1));
      send = 1'b0;
      wait_ack(1'b0, e);
      drain();

      // 2: single transfer, send held 10 cycles
      cur_data = 4'hA;
      dados    = 4'hA;
      send     = 1'b1;
      wait_ack(1'b1, e);
      check("t2_ack_latency", 32'(e), 32'(SYNC_STAGES + 1));
      check("t2_dout", 32'(dout), 32'hA);
      repeat (10) tick();
      check("t2_single_write", 32'(count), 32'd1);
      send = 1'b0;
      wait_ack(1'b0, e);
      check("t2_ack_fall_latency", 32'(e), 32'(SYNC_STAGES + 1));
      drain();

      // 3: fill and stall, then release by one pop
      for (int i = 1; i <= 4; i++) send_nib(DATA_W'(i), 0);
      cur_data = 4'h5;
      dados    = 4'h5;
      send     = 1'b1;
      repeat (10) tick();
      check("t3_stall_ack", 32'(ack), 32'd0);
      check("t3_full", 32'(full), 32'd1);
      check("t3_count", 32'(count), 32'd4);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      check("t3_no_write_on_pop_edge", 32'(ack), 32'd0);
      tick();
      check("t3_ack_after_pop", 32'(ack), 32'd1);
      check("t3_count_refill", 32'(count), 32'd4);
      send = 1'b0;
      wait_ack(1'b0, e);

      // 4: drain across pointer wrap while sending
      dout_ready = 1'b1;
      for (int i = 6; i <= 9; i++) send_nib(DATA_W'(i), 0);
      drain();
      check("t4_count_zero", 32'(count), 32'd0);

      // 5: simultaneous write and pop at count=2
      send_nib(4'hB, 0);
      send_nib(4'hD, 0);
      cur_data = 4'hE;
      dados    = 4'hE;
      send     = 1'b1;
      repeat (SYNC_STAGES) tick();
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      check("t5_ack", 32'(ack), 32'd1);
      check("t5_count_kept", 32'(count), 32'd2);
      check("t5_head_advanced", 32'(dout), 32'hD);
      send = 1'b0;
      wait_ack(1'b0, e);
      drain();

      // 6: asynchronous reset while in WAIT_DROP with count=3
      send_nib(4'h7, 0);
      send_nib(4'h8, 0);
      cur_data = 4'h9;
      dados    = 4'h9;
      send     = 1'b1;
      wait_ack(1'b1, e);
      check("t6_count_before", 32'(count), 32'd3);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("t6_async_ack", 32'(ack), 32'd0);
      check("t6_async_count", 32'(count), 32'd0);
      check("t6_async_valid", 32'(dout_valid), 32'd0);
      send = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      send_nib(4'hC, 0);
      check("t6_only_entry_count", 32'(count), 32'd1);
      check("t6_only_entry_dout", 32'(dout), 32'hC);
      drain();

      // Random traffic with a random-paced consumer
      rand_ready_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send_nib(DATA_W'($urandom), int'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_ready_en = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
